// File: rtl/dmux_pkg.sv
// Shared definitions for the registered N-way demultiplexer: select-width
// helper, drop-counter sizing and the per-slot state encoding.
package dmux_pkg;

  // Width of the drop counter and the value at which it stops counting.
  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = 8'd255;

  // Occupancy state of one output slot.
  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Bits needed to index n channels; never less than one bit.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dmux_chan_slot.sv
// One registered output slot: a valid/data pair governed by a two-state
// EMPTY/FULL machine. The slot can accept a word when it is empty or when its
// current word is being taken in the same cycle.
module dmux_chan_slot
  import dmux_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             free,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  slot_state_t      state_reg;
  slot_state_t      state_next;
  logic [WIDTH-1:0] data_reg;

  // State and data registers; reset discards any word held in the slot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= SLOT_EMPTY;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        data_reg <= load_data;
      end
    end
  end

  // Next-state: a load always ends FULL; FULL only empties when drained without a reload.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SLOT_EMPTY: begin
        if (load) begin
          state_next = SLOT_FULL;
        end
      end
      SLOT_FULL: begin
        if (out_ready && !load) begin
          state_next = SLOT_EMPTY;
        end
      end
      default: state_next = SLOT_EMPTY;
    endcase
  end

  assign out_valid = (state_reg == SLOT_FULL);
  assign free      = (state_reg == SLOT_EMPTY) || out_ready;
  assign out_data  = data_reg;

endmodule

// File: rtl/dmux_nway_reg.sv
// Registered N-way demultiplexer. Routes one WIDTH-bit word per cycle to the
// slot picked by in_sel, or to every slot at once in broadcast mode. Words
// with an out-of-range select are accepted and dropped, flagged by a one-cycle
// err_sel pulse and counted in a saturating drop counter.
module dmux_nway_reg
  import dmux_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = sel_width(CHANNELS),
  parameter int BCAST_EN = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_bcast,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err_sel,
  output logic [DROP_W-1:0]         drop_cnt
);

  // Channel count widened by one bit so in_sel can be range-checked even
  // when CHANNELS is an exact power of two.
  localparam logic [SEL_W:0] CHAN_LIM = (SEL_W + 1)'(CHANNELS);

  logic [CHANNELS-1:0] free;
  logic [CHANNELS-1:0] sel_onehot;
  logic [CHANNELS-1:0] load;
  logic                bcast_eff;
  logic                sel_ok;
  logic                accept;
  logic                drop_now;
  logic                err_sel_reg;
  logic [DROP_W-1:0]   drop_cnt_reg;

  // Select decoder and one slot per channel.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi = gi + 1) begin : g_chan
      localparam logic [SEL_W-1:0] IDX = SEL_W'(gi);

      assign sel_onehot[gi] = (in_sel == IDX);

      dmux_chan_slot #(
        .WIDTH (WIDTH)
      ) u_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load[gi]),
        .load_data (in_data),
        .out_ready (out_ready[gi]),
        .free      (free[gi]),
        .out_valid (out_valid[gi]),
        .out_data  (out_data[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // Accept logic: in_ready never looks at in_valid; broadcast is all-or-none.
  always_comb begin
    bcast_eff = (BCAST_EN != 0) && in_bcast;
    sel_ok    = ({1'b0, in_sel} < CHAN_LIM);
    in_ready  = 1'b0;
    load      = '0;

    if (bcast_eff) begin
      in_ready = &free;
    end else if (!sel_ok) begin
      in_ready = 1'b1;
    end else begin
      in_ready = |(sel_onehot & free);
    end

    accept = in_valid && in_ready;

    if (accept) begin
      if (bcast_eff) begin
        load = '1;
      end else if (sel_ok) begin
        load = sel_onehot;
      end
    end

    drop_now = accept && !bcast_eff && !sel_ok;
  end

  // Error pulse follows a dropped word by one cycle; drop counter saturates.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_sel_reg  <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      err_sel_reg <= drop_now;
      if (drop_now && (drop_cnt_reg != DROP_MAX)) begin
        drop_cnt_reg <= drop_cnt_reg + 1'b1;
      end
    end
  end

  assign err_sel  = err_sel_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule
